dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Sequencing controller and two-way arbiter for the single-port data memory behind the MEM stage. Shares the memory between the core's MEM stage (requester 0, `core`) and the loader/debug port (requester 1, `dbg`). Round-robin grant, one outstanding transaction, fixed memory read latency. Read data and write acknowledges are returned on a registered per-requester response port.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 2, cycles from a `mem_req_o` cycle to valid `mem_rdata_i`; legal range 1..7

Ports:
- `clk_i`  in  1  clock; all state on rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `core_req_valid_i` / `dbg_req_valid_i`  in  1  request valid; payload held stable until accepted
- `core_req_ready_o` / `dbg_req_ready_o`  out  1  request accepted this cycle when valid && ready
- `core_req_addr_i` / `dbg_req_addr_i`  in  ADDR_W  byte address
- `core_req_wdata_i` / `dbg_req_wdata_i`  in  DATA_W  store data
- `core_req_we_i` / `dbg_req_we_i`  in  1  1 = store, 0 = load
- `core_rsp_valid_o` / `dbg_rsp_valid_o`  out  1  one-cycle response pulse
- `core_rsp_rdata_o` / `dbg_rsp_rdata_o`  out  DATA_W  load data; 0 for store responses
- `mem_req_o`  out  1  memory access strobe, exactly one cycle per transaction
- `mem_we_o`  out  1  memory write enable, valid with `mem_req_o`
- `mem_addr_o`  out  ADDR_W  memory address
- `mem_wdata_o`  out  DATA_W  memory write data
- `mem_rdata_i`  in  DATA_W  read data, valid exactly MEM_LAT cycles after `mem_req_o`

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Requests are accepted only in IDLE or RESP.
  - On accept, the request is latched into the request register (addr, wdata, we, owner).
  - The FSM then goes to ISSUE. With no accept, IDLE stays IDLE and RESP goes to IDLE.
- ISSUE lasts one cycle:
  - `mem_req_o`=1; `mem_we_o`/`mem_addr_o`/`mem_wdata_o` are driven from the request register.
  - The latency counter is loaded with MEM_LAT, then the FSM goes to WAIT.
- WAIT: the counter decrements each cycle.
  - In the cycle the counter equals 1, `mem_rdata_i` is captured into the response register; a store captures 0.
  - The FSM then goes to RESP.
- RESP: `rsp_valid_o` of the owner pulses for one cycle. The other requester's `rsp_valid_o` stays 0.
- Stores follow the same sequence and latency as loads, so the response doubles as the write ack.
- Arbitration:
  - The `last` register holds the most recently granted requester.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to `last` is granted.
  - `ready_o` is high only for the granted requester, and only in IDLE/RESP.
  - `ready_o` may depend combinationally on `*_req_valid_i`.
  - `last` updates on accept only.
- The counter is 3 bits wide; MEM_LAT outside 1..7 is a build-time assertion failure.
- Reset (asynchronous, effective immediately):
  - FSM goes to IDLE.
  - `last` resets to dbg, so core wins the first contention.
  - Counter and request/response registers clear to 0.
  - All outputs read 0.
  - An in-flight transaction is discarded with no response. A store whose ISSUE cycle completed before reset has already been written.

## Timing
- Accept in cycle A (IDLE) gives ISSUE/`mem_req_o` in A+1, capture in A+1+MEM_LAT, and `rsp_valid_o` in A+2+MEM_LAT.
- Accept during RESP starts the next ISSUE the following cycle. Sustained throughput is one transaction per MEM_LAT+2 cycles.
- Outputs `mem_*` and `*_rsp_*` are registers or decode directly from state registers. Only `*_req_ready_o` is combinational.
- No requester can be starved: under continuous contention, grants alternate core/dbg.

## Structure
- Add to `tartaruga_pkg`:
  - `dmem_arb_state_e`: IDLE/ISSUE/WAIT/RESP.
  - `dmem_req_t`: addr, wdata, we.
  - `dmem_owner_e`: CORE/DBG.
- Sub-module `rr_arbiter2`: two valids plus `last` in, one-hot grant out, purely combinational. Everything else lives in `dmem_arbiter`.

## Test plan
All scenarios use MEM_LAT=2.
- Reset release, then core load addr 0x10 with the memory model returning 0xDEADBEEF:
  - `core_req_ready_o`=1 in cycle A.
  - `mem_req_o`=1, `mem_we_o`=0 in A+1.
  - `core_rsp_valid_o`=1 with rdata 0xDEADBEEF in A+4.
  - `dbg_rsp_valid_o` stays 0.
- Dbg store 0x55 to addr 0x20:
  - `mem_we_o`=1, `mem_wdata_o`=0x55 for exactly one cycle.
  - `dbg_rsp_valid_o`=1 with rdata 0 four cycles after accept.
  - A following core load of 0x20 returns 0x55.
- Both valid continuously after reset:
  - Grant order is core, dbg, core, dbg.
  - Accepts occur every 4 cycles, each in the RESP cycle of the previous transaction.
  - `mem_req_o` is never high in two consecutive cycles.
- Core valid held with dbg idle: four back-to-back core loads complete in 16 cycles, and `last` stays core.
- Assert `rst_i` during WAIT of a core load:
  - All outputs go 0 immediately.
  - No `rsp_valid_o` follows.
  - After release, a dbg request is granted in the first IDLE cycle.
- Request presented while the FSM is in ISSUE/WAIT: `ready_o`=0 and the request payload is not sampled until RESP.

Source files
------------

// File: rtl/tartaruga_pkg.sv
// Shared types and widths for the tartaruga MEM-stage data memory path.
package tartaruga_pkg;

    localparam int unsigned DMEM_ADDR_W = 32;
    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned DMEM_CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } dmem_arb_state_e;

    typedef enum logic {
        CORE = 1'b0,
        DBG  = 1'b1
    } dmem_owner_e;

    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic                   we;
    } dmem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on contention the requester that was not granted last wins.
module rr_arbiter2
    import tartaruga_pkg::*;
(
    input  logic [1:0]  i_valid,
    input  dmem_owner_e i_last,
    output logic [1:0]  o_grant_c
);

    always_comb begin
        o_grant_c = 2'b00;
        case (i_valid)
            2'b01:   o_grant_c = 2'b01;
            2'b10:   o_grant_c = 2'b10;
            2'b11:   o_grant_c = (i_last == CORE) ? 2'b10 : 2'b01;
            default: o_grant_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Sequences single-port data memory accesses and arbitrates core vs. debug,
// one transaction in flight, fixed read latency, registered per-requester responses.
module dmem_arbiter
    import tartaruga_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              core_req_valid_i,
    output logic              core_req_ready_o,
    input  logic [ADDR_W-1:0] core_req_addr_i,
    input  logic [DATA_W-1:0] core_req_wdata_i,
    input  logic              core_req_we_i,
    output logic              core_rsp_valid_o,
    output logic [DATA_W-1:0] core_rsp_rdata_o,

    input  logic              dbg_req_valid_i,
    output logic              dbg_req_ready_o,
    input  logic [ADDR_W-1:0] dbg_req_addr_i,
    input  logic [DATA_W-1:0] dbg_req_wdata_i,
    input  logic              dbg_req_we_i,
    output logic              dbg_rsp_valid_o,
    output logic [DATA_W-1:0] dbg_rsp_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    if ((MEM_LAT == 0) || (MEM_LAT > 7)) begin : g_bad_mem_lat
        $error("dmem_arbiter: MEM_LAT=%0d outside 1..7", MEM_LAT);
    end
    if ((ADDR_W != DMEM_ADDR_W) || (DATA_W != DMEM_DATA_W)) begin : g_bad_width
        $error("dmem_arbiter: ADDR_W/DATA_W must match tartaruga_pkg widths");
    end

    localparam logic [DMEM_CNT_W-1:0] LAT_CNT = DMEM_CNT_W'(MEM_LAT);
    localparam logic [DMEM_CNT_W-1:0] CNT_ONE = DMEM_CNT_W'(1);

    dmem_arb_state_e         r_state;
    dmem_arb_state_e         w_next_state;
    logic [DMEM_CNT_W-1:0]   r_cnt;
    dmem_req_t               r_req;
    dmem_owner_e             r_owner;
    dmem_owner_e             r_last;
    logic [DATA_W-1:0]       r_rdata;

    logic [1:0]              w_grant;
    logic                    w_can_accept;
    logic                    w_accept;
    dmem_req_t               w_core_req;
    dmem_req_t               w_dbg_req;

    rr_arbiter2 u_rr_arbiter2 (
        .i_valid   ({dbg_req_valid_i, core_req_valid_i}),
        .i_last    (r_last),
        .o_grant_c (w_grant)
    );

    // Reset gates acceptance so ready reads 0 while rst_i is held.
    assign w_can_accept = !rst_i && ((r_state == IDLE) || (r_state == RESP));
    assign w_accept     = w_can_accept && (w_grant != 2'b00);

    assign w_core_req = '{addr:  DMEM_ADDR_W'(core_req_addr_i),
                          wdata: DMEM_DATA_W'(core_req_wdata_i),
                          we:    core_req_we_i};
    assign w_dbg_req  = '{addr:  DMEM_ADDR_W'(dbg_req_addr_i),
                          wdata: DMEM_DATA_W'(dbg_req_wdata_i),
                          we:    dbg_req_we_i};

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and output decode
    always_comb begin
        w_next_state     = r_state;
        core_req_ready_o = 1'b0;
        dbg_req_ready_o  = 1'b0;
        core_rsp_valid_o = 1'b0;
        core_rsp_rdata_o = '0;
        dbg_rsp_valid_o  = 1'b0;
        dbg_rsp_rdata_o  = '0;
        mem_req_o        = 1'b0;
        mem_we_o         = 1'b0;
        mem_addr_o       = '0;
        mem_wdata_o      = '0;

        case (r_state)
            IDLE:    if (w_accept) w_next_state = ISSUE;
            ISSUE:   w_next_state = WAIT;
            WAIT:    if (r_cnt == CNT_ONE) w_next_state = RESP;
            RESP:    w_next_state = w_accept ? ISSUE : IDLE;
            default: w_next_state = IDLE;
        endcase

        core_req_ready_o = w_can_accept && w_grant[0];
        dbg_req_ready_o  = w_can_accept && w_grant[1];

        if (r_state == ISSUE) begin
            mem_req_o   = 1'b1;
            mem_we_o    = r_req.we;
            mem_addr_o  = ADDR_W'(r_req.addr);
            mem_wdata_o = DATA_W'(r_req.wdata);
        end

        if (r_state == RESP) begin
            if (r_owner == CORE) begin
                core_rsp_valid_o = 1'b1;
                core_rsp_rdata_o = r_rdata;
            end else begin
                dbg_rsp_valid_o  = 1'b1;
                dbg_rsp_rdata_o  = r_rdata;
            end
        end
    end

    // Request latch, latency counter and response capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_req   <= '0;
            r_owner <= CORE;
            r_last  <= DBG;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_req   <= w_grant[1] ? w_dbg_req : w_core_req;
                r_owner <= w_grant[1] ? DBG : CORE;
                r_last  <= w_grant[1] ? DBG : CORE;
            end
            if (r_state == ISSUE) begin
                r_cnt <= LAT_CNT;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - CNT_ONE;
                // Stores return 0 so the response is a plain write ack.
                if (r_cnt == CNT_ONE) begin
                    r_rdata <= r_req.we ? '0 : mem_rdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised scoreboard bench for dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;

    localparam int MEM_LAT = 2;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } stim_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          due;
    } mem_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req_valid_i, dbg_req_valid_i;
    logic        core_req_ready_o, dbg_req_ready_o;
    logic [31:0] core_req_addr_i, dbg_req_addr_i;
    logic [31:0] core_req_wdata_i, dbg_req_wdata_i;
    logic        core_req_we_i, dbg_req_we_i;
    logic        core_rsp_valid_o, dbg_rsp_valid_o;
    logic [31:0] core_rsp_rdata_o, dbg_rsp_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .core_req_valid_i (core_req_valid_i),
        .core_req_ready_o (core_req_ready_o),
        .core_req_addr_i  (core_req_addr_i),
        .core_req_wdata_i (core_req_wdata_i),
        .core_req_we_i    (core_req_we_i),
        .core_rsp_valid_o (core_rsp_valid_o),
        .core_rsp_rdata_o (core_rsp_rdata_o),
        .dbg_req_valid_i  (dbg_req_valid_i),
        .dbg_req_ready_o  (dbg_req_ready_o),
        .dbg_req_addr_i   (dbg_req_addr_i),
        .dbg_req_wdata_i  (dbg_req_wdata_i),
        .dbg_req_we_i     (dbg_req_we_i),
        .dbg_rsp_valid_o  (dbg_rsp_valid_o),
        .dbg_rsp_rdata_o  (dbg_rsp_rdata_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_rdata_i      (mem_rdata_i)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state: memory contents, who won last, when the next accept is allowed.
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] env_mem [logic [31:0]];
    bit          last_dbg    = 1'b1;
    int          busy_until  = 0;
    bit          core_acc    = 1'b0;
    bit          dbg_acc     = 1'b0;

    stim_t    core_sq[$], dbg_sq[$];
    rsp_exp_t core_eq[$], dbg_eq[$];
    mem_exp_t mem_eq[$];
    rsp_exp_t rd_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] env_read(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : 32'h0;
    endfunction

    // Cycle count, request driver and memory read-data driver.
    always @(posedge clk) begin
        stim_t s;
        cyc = cyc + 1;
        #1;
        if (core_acc) begin core_req_valid_i = 1'b0; core_acc = 1'b0; end
        if (dbg_acc)  begin dbg_req_valid_i  = 1'b0; dbg_acc  = 1'b0; end
        if (!core_req_valid_i && core_sq.size() > 0) begin
            s = core_sq.pop_front();
            core_req_valid_i = 1'b1;
            core_req_we_i    = s.we;
            core_req_addr_i  = s.addr;
            core_req_wdata_i = s.wdata;
        end
        if (!dbg_req_valid_i && dbg_sq.size() > 0) begin
            s = dbg_sq.pop_front();
            dbg_req_valid_i = 1'b1;
            dbg_req_we_i    = s.we;
            dbg_req_addr_i  = s.addr;
            dbg_req_wdata_i = s.wdata;
        end
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            mem_rdata_i = rd_q[0].data;
            void'(rd_q.pop_front());
        end else begin
            mem_rdata_i = $urandom();
        end
    end

    // Memory environment: stores update, loads return data MEM_LAT cycles after the strobe.
    always @(negedge clk) begin
        if (!rst && mem_req_o) begin
            if (mem_we_o) env_mem[mem_addr_o] = mem_wdata_o;
            else          rd_q.push_back('{data: env_read(mem_addr_o), due: cyc + MEM_LAT});
        end
    end

    // Arbitration model: checks ready and pushes expectations on every modelled accept.
    always @(negedge clk) begin
        bit    can, gc, gd;
        stim_t s;
        if (!rst) begin
            can = (cyc >= busy_until);
            gc  = core_req_valid_i && (!dbg_req_valid_i || last_dbg);
            gd  = dbg_req_valid_i && (!core_req_valid_i || !last_dbg);
            check("core_ready", 64'(core_req_ready_o), 64'(can && gc));
            check("dbg_ready",  64'(dbg_req_ready_o),  64'(can && gd));
            if (can && (gc || gd)) begin
                s = gd ? '{we: dbg_req_we_i, addr: dbg_req_addr_i, wdata: dbg_req_wdata_i}
                       : '{we: core_req_we_i, addr: core_req_addr_i, wdata: core_req_wdata_i};
                mem_eq.push_back('{we: s.we, addr: s.addr, wdata: s.wdata, due: cyc + 1});
                if (gd) dbg_eq.push_back('{data: s.we ? 32'h0 : ref_read(s.addr), due: cyc + MEM_LAT + 2});
                else    core_eq.push_back('{data: s.we ? 32'h0 : ref_read(s.addr), due: cyc + MEM_LAT + 2});
                if (s.we) ref_mem[s.addr] = s.wdata;
                last_dbg   = gd;
                busy_until = cyc + MEM_LAT + 2;
                if (gd) dbg_acc = 1'b1;
                else    core_acc = 1'b1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT strobes memory or responds.
    always @(negedge clk) begin
        rsp_exp_t e;
        mem_exp_t m;
        if (!rst) begin
            if (core_rsp_valid_o) begin
                if (core_eq.size() == 0) fail_now("core_rsp_unexpected");
                else begin
                    e = core_eq.pop_front();
                    check("core_rsp_data",  64'(core_rsp_rdata_o), 64'(e.data));
                    check("core_rsp_cycle", 64'(cyc), 64'(e.due));
                end
            end else if (core_eq.size() > 0 && core_eq[0].due < cyc) begin
                fail_now("core_rsp_missing");
                void'(core_eq.pop_front());
            end
            if (dbg_rsp_valid_o) begin
                if (dbg_eq.size() == 0) fail_now("dbg_rsp_unexpected");
                else begin
                    e = dbg_eq.pop_front();
                    check("dbg_rsp_data",  64'(dbg_rsp_rdata_o), 64'(e.data));
                    check("dbg_rsp_cycle", 64'(cyc), 64'(e.due));
                end
            end else if (dbg_eq.size() > 0 && dbg_eq[0].due < cyc) begin
                fail_now("dbg_rsp_missing");
                void'(dbg_eq.pop_front());
            end
            if (mem_req_o) begin
                if (mem_eq.size() == 0) fail_now("mem_req_unexpected");
                else begin
                    m = mem_eq.pop_front();
                    check("mem_we",    64'(mem_we_o),    64'(m.we));
                    check("mem_addr",  64'(mem_addr_o),  64'(m.addr));
                    check("mem_wdata", 64'(mem_wdata_o), 64'(m.wdata));
                    check("mem_cycle", 64'(cyc),         64'(m.due));
                end
            end else if (mem_eq.size() > 0 && mem_eq[0].due < cyc) begin
                fail_now("mem_req_missing");
                void'(mem_eq.pop_front());
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 64'({core_req_ready_o, dbg_req_ready_o, core_rsp_valid_o,
                                  dbg_rsp_valid_o, mem_req_o, mem_we_o}), 64'(0));
        check({tag, "_mem_addr"},  64'(mem_addr_o),       64'(0));
        check({tag, "_mem_wdata"}, 64'(mem_wdata_o),      64'(0));
        check({tag, "_core_rdat"}, 64'(core_rsp_rdata_o), 64'(0));
        check({tag, "_dbg_rdat"},  64'(dbg_rsp_rdata_o),  64'(0));
    endtask

    // Mid-cycle reset pulse; in-flight work is dropped from the model.
    task automatic pulse_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("rst_async");
        core_eq.delete(); dbg_eq.delete(); mem_eq.delete(); rd_q.delete();
        last_dbg = 1'b1; busy_until = 0;
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (core_sq.size() != 0 || dbg_sq.size() != 0 || core_req_valid_i || dbg_req_valid_i ||
               core_eq.size() != 0 || dbg_eq.size() != 0 || mem_eq.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                fail_now("drain_timeout");
                break;
            end
        end
        @(negedge clk);
        #1;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.we    = 1'($urandom_range(0, 1));
        s.addr  = 32'($urandom_range(0, 15) * 4);
        s.wdata = $urandom();
        return s;
    endfunction

    initial begin
        int n;
        rst = 1'b1;
        core_req_valid_i = 1'b0; core_req_we_i = 1'b0; core_req_addr_i = '0; core_req_wdata_i = '0;
        dbg_req_valid_i  = 1'b0; dbg_req_we_i  = 1'b0; dbg_req_addr_i  = '0; dbg_req_wdata_i  = '0;
        mem_rdata_i = '0;
        env_mem[32'h10] = 32'hDEADBEEF;
        ref_mem[32'h10] = 32'hDEADBEEF;
        #2 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // Core load from a preloaded word
        @(negedge clk); #1;
        core_sq.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
        wait_idle();

        // Debug store followed by a core load of the same word
        dbg_sq.push_back('{we: 1'b1, addr: 32'h20, wdata: 32'h55});
        wait_idle();
        core_sq.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0});
        wait_idle();

        // Continuous contention from reset: grants must alternate starting with core
        pulse_reset();
        @(negedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            core_sq.push_back(rand_stim());
            dbg_sq.push_back(rand_stim());
        end
        wait_idle();

        // Back-to-back core loads with debug idle
        for (int i = 0; i < 4; i++) core_sq.push_back('{we: 1'b0, addr: 32'(i * 4), wdata: $urandom()});
        wait_idle();

        // Reset while a core load waits on memory: no response may follow
        core_sq.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req_o && n < 50);
        if (!mem_req_o) fail_now("wait_for_issue");
        pulse_reset();
        dbg_sq.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0});
        wait_idle();

        // Random traffic from both requesters
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); #1;
            if ($urandom_range(0, 3) == 0 && core_sq.size() < 2) core_sq.push_back(rand_stim());
            if ($urandom_range(0, 3) == 0 && dbg_sq.size() < 2)  dbg_sq.push_back(rand_stim());
        end
        wait_idle();
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
